// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared ALU and a unified
// variable-latency memory, producing every datapath select and enable.
module mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_op,
  output logic [2:0]       alu_op,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             retire,
  output logic             illegal,
  output logic             mem_err,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_SLL   = 6'b000000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_LUI  = 3'b100;

  localparam int unsigned      WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_HALT   = 4'd10
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [2:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       retire;
    logic       illegal;
  } ctl_t;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ctl_t              ctl_c, ctl_o;

  // The zero flag is combined with pc_write_cond inside the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  logic is_rtype, is_lw, is_sw, is_addu, is_subu, is_ori, is_lui;
  logic is_beq, is_j, is_jal, is_jr, is_nop;

  assign is_rtype = (op == OP_RTYPE);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_addu  = is_rtype && (funct == FN_ADDU);
  assign is_subu  = is_rtype && (funct == FN_SUBU);
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_nop   = is_rtype && (funct == FN_SLL);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_beq   = (op == OP_BEQ);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);

  // Next state, Moore control decode, memory wait/timeout and retire count.
  always_comb begin
    ctl_c   = '0;
    state_d = state_q;
    wait_d  = '0;
    err_d   = err_q;

    unique case (state_q)
      S_FETCH: begin
        ctl_c.mem_req   = 1'b1;
        ctl_c.mem_read  = 1'b1;
        ctl_c.alu_src_b = 2'b01;
        ctl_c.alu_op    = ALU_ADD;
        ctl_c.ir_write  = mem_ready;
        ctl_c.pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctl_c.alu_src_b = 2'b11;
        ctl_c.alu_op    = ALU_ADD;
        if (is_lw || is_sw)                         state_d = S_MEMADR;
        else if (is_addu || is_subu || is_ori || is_lui) state_d = S_EXEC;
        else if (is_beq)                            state_d = S_BRANCH;
        else if (is_j || is_jal || is_jr)           state_d = S_JUMP;
        else begin
          state_d = S_FETCH;
          if (is_nop) ctl_c.retire  = 1'b1;
          else        ctl_c.illegal = 1'b1;
        end
      end
      S_MEMADR: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = 2'b10;
        ctl_c.alu_op    = ALU_ADD;
        state_d = is_lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctl_c.mem_req  = 1'b1;
        ctl_c.mem_read = 1'b1;
        ctl_c.iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctl_c.reg_write  = 1'b1;
        ctl_c.mem_to_reg = 2'b01;
        ctl_c.retire     = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        ctl_c.mem_req   = 1'b1;
        ctl_c.mem_write = 1'b1;
        ctl_c.iord      = 1'b1;
        ctl_c.retire    = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        ctl_c.alu_src_a = 1'b1;
        if (is_ori || is_lui) begin
          ctl_c.alu_src_b = 2'b10;
          ctl_c.ext_op    = 1'b1;
          ctl_c.alu_op    = is_lui ? ALU_LUI : ALU_OR;
        end else begin
          ctl_c.alu_op    = is_subu ? ALU_SUB : ALU_ADD;
        end
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ctl_c.reg_write = 1'b1;
        ctl_c.reg_dst   = is_rtype ? 2'b01 : 2'b00;
        ctl_c.retire    = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ctl_c.alu_src_a     = 1'b1;
        ctl_c.alu_op        = ALU_SUB;
        ctl_c.pc_write_cond = 1'b1;
        ctl_c.pc_src        = 2'b01;
        ctl_c.retire        = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        ctl_c.pc_write = 1'b1;
        ctl_c.retire   = 1'b1;
        ctl_c.pc_src   = is_jr ? 2'b11 : 2'b10;
        if (is_jal) begin
          ctl_c.reg_write  = 1'b1;
          ctl_c.reg_dst    = 2'b10;
          ctl_c.mem_to_reg = 2'b10;
        end
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Every memory state exits only on mem_ready, so clearing on ready or
    // outside a memory state is the same as clearing on entry.
    if (ctl_c.mem_req && !mem_ready) begin
      if (wait_q == TMO_LAST) begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end

    cnt_d = cnt_q + CNT_W'(ctl_c.retire);
  end

  // State, wait counter, sticky error and retire counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low combinationally so a reset aborts any write at once.
  assign ctl_o = reset ? ctl_c : '0;

  assign mem_req       = ctl_o.mem_req;
  assign iord          = ctl_o.iord;
  assign mem_read      = ctl_o.mem_read;
  assign mem_write     = ctl_o.mem_write;
  assign ir_write      = ctl_o.ir_write;
  assign pc_write      = ctl_o.pc_write;
  assign pc_write_cond = ctl_o.pc_write_cond;
  assign pc_src        = ctl_o.pc_src;
  assign alu_src_a     = ctl_o.alu_src_a;
  assign alu_src_b     = ctl_o.alu_src_b;
  assign ext_op        = ctl_o.ext_op;
  assign alu_op        = ctl_o.alu_op;
  assign reg_dst       = ctl_o.reg_dst;
  assign mem_to_reg    = ctl_o.mem_to_reg;
  assign reg_write     = ctl_o.reg_write;
  assign retire        = ctl_o.retire;
  assign illegal       = ctl_o.illegal;
  assign state         = reset ? state_q : 4'd0;
  assign mem_err       = err_q;
  assign instr_cnt     = cnt_q;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath: one shared ALU and one unified instruction/data memory, with IR, MDR, A, B and ALUOut registers.
- Decodes opcode/funct captured in IR and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Emits all datapath mux selects and write enables, and handshakes with a variable-latency memory.
- Sits between the instruction register and the datapath inside the multi-cycle CPU top.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting for mem_ready before flagging mem_err.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes current access this cycle.
- mem_req  out  1  memory access request.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- pc_src  out  2  PC source: 00 ALU, 01 ALUOut, 10 {PC[31:28],IR[25:0],00}, 11 A.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 B, 01 const 4, 10 extended imm, 11 sign-ext imm<<2.
- ext_op  out  1  imm extension: 0 = sign, 1 = zero.
- alu_op  out  3  000 ADD, 001 SUB, 010 OR, 011 AND, 100 LUI (B<<16).
- reg_dst  out  2  write register: 00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  write data: 00 ALUOut, 01 MDR, 10 PC.
- reg_write  out  1  GRF write enable.
- retire  out  1  one-cycle pulse on last cycle of each instruction.
- illegal  out  1  one-cycle pulse on undecoded instruction.
- mem_err  out  1  sticky; set on memory timeout.
- state  out  4  current state, debug.
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, HALT 10.
- Outputs are decoded from state (Moore). Exceptions: ir_write, pc_write in FETCH, and retire are gated by mem_ready where noted.
- Unlisted outputs are 0 in every state.
- While reset is low: state = FETCH, every output = 0, instr_cnt = 0, mem_err = 0, wait counter = 0.
- FETCH: mem_req=1, mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00.
  - ir_write and pc_write equal mem_ready.
  - Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (precomputes branch target). Next state:
  - lw (100011) or sw (101011) -> MEMADR.
  - R-type (000000) with addu (100001), subu (100011), ori (001101) or lui (001111) -> EXEC.
  - beq (000100) -> BRANCH.
  - j (000010), jal (000011), or R-type jr (001000) -> JUMP.
  - R-type funct 000000 (nop/sll) -> FETCH, retire=1.
  - Anything else -> FETCH, illegal=1, no retire.
- MEMADR: alu_src_a=1, alu_src_b=10, ext_op=0, alu_op=ADD. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, mem_read=1, iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01, retire=1. Next: FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Hold until mem_ready; retire=mem_ready; then go to FETCH.
- EXEC: alu_src_a=1.
  - addu: alu_src_b=00, ADD.
  - subu: alu_src_b=00, SUB.
  - ori: alu_src_b=10, ext_op=1, OR.
  - lui: alu_src_b=10, ext_op=1, LUI.
  - Next: ALUWB.
- ALUWB: reg_write=1, mem_to_reg=00, reg_dst=01 for R-type, 00 otherwise; retire=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1, pc_src=01, retire=1. Next: FETCH.
- JUMP: pc_write=1, retire=1. Next: FETCH.
  - j: pc_src=10.
  - jal: pc_src=10, plus reg_write=1, reg_dst=10, mem_to_reg=10. The PC value written is the already-incremented PC+4.
  - jr: pc_src=11.
- Memory wait counter:
  - Clears on entry to any memory state; increments each cycle mem_req=1 and mem_ready=0.
  - On reaching MEM_TIMEOUT: mem_err=1 (sticky), go to HALT.
  - HALT: all outputs 0. Left only by reset.
- instr_cnt increments on every retire pulse and wraps modulo 2^CNT_W.
- CPI with zero-wait memory: lw 5, sw 4, R/ori/lui 4, beq 3, j/jal/jr 3, nop 2.
- Reset asserted mid-instruction aborts immediately, with no register or memory write completing afterwards.

Test Plan:
- Reset low 3 cycles, release with mem_ready=1 -> all outputs 0 during reset; first cycle after release state=0, mem_req=1, ir_write=1, pc_write=1.
- Sequence lw, sw, addu, beq (zero=1), j, jal with mem_ready=1 -> states 0,1,2,3,4 / 0,1,2,5 / 0,1,6,7 / 0,1,8 / 0,1,9 / 0,1,9; instr_cnt=6. jal shows reg_dst=10, mem_to_reg=10.
- lw with mem_ready low 3 cycles in FETCH and 2 in MEMRD -> ir_write only on the ready cycle; total 10 cycles; single retire.
- op=111111 -> DECODE then FETCH, illegal pulses once, instr_cnt unchanged.
- mem_ready held 0 in MEMWR -> after 16 cycles mem_err=1, state=10, mem_write=0; stays until reset.
- Preload instr_cnt near wrap with CNT_W=4, execute 17 nops -> count wraps to 1; assert reset during MEMWB cycle -> reg_write falls immediately.
